// File: rtl/msg_pkg.sv
// msg_pkg -- shared definitions for the message serializer.
//   MSG_CHARS / CHAR_BITS : default message geometry
//   state_t               : controller states (IDLE, SEND, DONE)
//   clamp_len()           : maps a requested length onto 1..max_chars
//   even_parity()         : present only when MSG_SERIAL_PARITY_EN is defined
package msg_pkg;

  localparam int MSG_CHARS = 64;
  localparam int CHAR_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // A length of 0, or anything beyond the buffer, means "whole buffer".
  function automatic logic [6:0] clamp_len(input logic [6:0] len,
                                           input logic [6:0] max_chars);
    logic [6:0] res;
    if ((len == 7'd0) || (len > max_chars)) begin
      res = max_chars;
    end else begin
      res = len;
    end
    return res;
  endfunction

`ifdef MSG_SERIAL_PARITY_EN
  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [CHAR_BITS-1:0] c);
    return ^c;
  endfunction
`endif

endpackage

// File: rtl/msg_serial_ctrl_char_shift_reg.sv
// char_shift_reg -- holds the character currently on the wire and shifts it
// out MSB first. With MSG_SERIAL_PARITY_EN defined, an even-parity bit is
// appended below the LSB so it leaves after the character bits.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_char (plus parity) into the register
//   load_char  : character to transmit next
//   shift      : move to the next bit
//   msb        : bit currently presented
module char_shift_reg #(
  parameter int CHAR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CHAR_BITS-1:0] load_char,
  input  logic                 shift,
  output logic                 msb
);
`ifdef MSG_SERIAL_PARITY_EN
  import msg_pkg::*;
  localparam int W = CHAR_BITS + 1;
  logic [W-1:0] load_val_s;
  assign load_val_s = {load_char, even_parity(load_char)};
`else
  localparam int W = CHAR_BITS;
  logic [W-1:0] load_val_s;
  assign load_val_s = load_char;
`endif

  logic [W-1:0] data_r;

  // Load has priority; the controller never asserts load and shift together.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= load_val_s;
    end else if (shift) begin
      data_r <= {data_r[W-2:0], 1'b0};
    end
  end

  assign msb = data_r[W-1];

endmodule

// File: rtl/msg_serial_ctrl.sv
// msg_serial_ctrl -- accepts a message of up to MSG_CHARS characters and
// streams it bit-serially (character 1 first, MSB first) over a
// valid/ready link to a modulator.
// Optional macro MSG_SERIAL_PARITY_EN: appends an even-parity bit after each
// character (9 bits per character); the port list is unchanged.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   msg_in, msg_len   : message (char 1 in the top byte) and length (0/>64 = 64)
//   msg_valid/ready   : upstream handshake, ready only in IDLE
//   bit_out/valid/ready : serial downstream handshake
//   char_idx          : zero-based index of the character on the wire
//   busy, frame_done  : frame in progress / one-cycle end-of-frame pulse
module msg_serial_ctrl #(
  parameter int MSG_CHARS = 64,
  parameter int CHAR_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MSG_CHARS*CHAR_BITS-1:0] msg_in,
  input  logic [6:0]                     msg_len,
  input  logic                           msg_valid,
  output logic                           msg_ready,
  output logic                           bit_out,
  output logic                           bit_valid,
  input  logic                           bit_ready,
  output logic [5:0]                     char_idx,
  output logic                           busy,
  output logic                           frame_done
);
  import msg_pkg::*;

  localparam int MSG_BITS = MSG_CHARS * CHAR_BITS;
`ifdef MSG_SERIAL_PARITY_EN
  localparam int BITS_PER_CHAR = CHAR_BITS + 1;
`else
  localparam int BITS_PER_CHAR = CHAR_BITS;
`endif
  localparam int              CNT_W    = $clog2(BITS_PER_CHAR);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_CHAR - 1);
  localparam logic [6:0]       MAX_LEN  = 7'(MSG_CHARS);

  state_t               state_r, state_next_s;
  logic [MSG_BITS-1:0]  msg_r;
  logic [6:0]           len_r;
  logic [5:0]           char_idx_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic                 accept_s, adv_s, last_bit_s, last_char_s;
  logic                 load_s, shift_s, sr_msb_s;
  logic [CHAR_BITS-1:0] load_char_s;

  assign last_bit_s  = (bit_cnt_r == LAST_BIT);
  assign last_char_s = ({1'b0, char_idx_r} == (len_r - 7'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and handshake qualifiers.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    adv_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (msg_valid) begin
          accept_s     = 1'b1;
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        adv_s = bit_ready;
        if (bit_ready && last_bit_s && last_char_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SEND;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Shift-register control: the first character comes straight from msg_in
  // on accept; later ones come from the second slot of msg_r, which is about
  // to move into the top slot on the same edge.
  always_comb begin
    load_s      = 1'b0;
    shift_s     = 1'b0;
    load_char_s = msg_in[MSG_BITS-1 -: CHAR_BITS];
    if (accept_s) begin
      load_s = 1'b1;
    end else if (adv_s && last_bit_s && !last_char_s) begin
      load_s      = 1'b1;
      load_char_s = msg_r[MSG_BITS-CHAR_BITS-1 -: CHAR_BITS];
    end else if (adv_s && !last_bit_s) begin
      shift_s = 1'b1;
    end else begin
      load_s  = 1'b0;
      shift_s = 1'b0;
    end
  end

  // Message buffer and bit/character counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_r      <= '0;
      len_r      <= 7'd0;
      char_idx_r <= 6'd0;
      bit_cnt_r  <= '0;
    end else if (accept_s) begin
      msg_r      <= msg_in;
      len_r      <= clamp_len(msg_len, MAX_LEN);
      char_idx_r <= 6'd0;
      bit_cnt_r  <= '0;
    end else if (adv_s) begin
      if (last_bit_s) begin
        bit_cnt_r <= '0;
        if (!last_char_s) begin
          char_idx_r <= char_idx_r + 6'd1;
          msg_r      <= msg_r << CHAR_BITS;
        end
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end else if (state_r == DONE) begin
      char_idx_r <= 6'd0;
    end
  end

  char_shift_reg #(
    .CHAR_BITS (CHAR_BITS)
  ) u_char_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_char (load_char_s),
    .shift     (shift_s),
    .msb       (sr_msb_s)
  );

  // Outputs are plain decodes of registered state.
  assign msg_ready  = (state_r == IDLE);
  assign bit_valid  = (state_r == SEND);
  assign busy       = (state_r == SEND);
  assign frame_done = (state_r == DONE);
  assign bit_out    = (state_r == SEND) & sr_msb_s;
  assign char_idx   = char_idx_r;

endmodule
